// File: rtl/secuencial_02.sv
// secuencial_02: registered N-channel W-bit multiplexer with manual, round-robin scan and hold modes
module secuencial_02 #(
    parameter int W     = 1,
    parameter int N     = 3,
    parameter int DWELL = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [1:0]             mode,
    input  logic [$clog2(N)-1:0]   sel,
    input  logic [N*W-1:0]         din,
    output logic [W-1:0]           z,
    output logic [$clog2(N)-1:0]   ch,
    output logic                   valid,
    output logic                   wrap
);
    localparam int SW = $clog2(N);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SW-1:0] LAST  = SW'(N - 1);
    localparam logic [SW:0]   NCH   = (SW + 1)'(N);
    localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);

    logic [SW-1:0] ptr;
    logic [DW-1:0] cnt;
    logic          in_range;
    logic          dwell_done;
    logic          scan_end;

    // sel may exceed N-1 when N is not a power of two; such picks are flagged invalid
    always_comb begin
        in_range   = {1'b0, sel} < NCH;
        dwell_done = cnt == DLAST;
        scan_end   = dwell_done && ptr == LAST;
    end

    // Capture, scan sequencing and wrap pulse; reset is active-low and overrides enable/mode
    always_ff @(posedge clk) begin
        if (!rst) begin
            z     <= '0;
            ch    <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
            cnt   <= '0;
            ptr   <= '0;
        end else begin
            wrap <= 1'b0;
            if (enable) begin
                if (mode == 2'b00) begin
                    z     <= in_range ? din[int'(sel)*W +: W] : '0;
                    ch    <= sel;
                    valid <= in_range;
                    cnt   <= '0;
                    ptr   <= '0;
                end else if (mode == 2'b01) begin
                    z     <= din[int'(ptr)*W +: W];
                    ch    <= ptr;
                    valid <= 1'b1;
                    cnt   <= dwell_done ? '0 : cnt + 1'b1;
                    ptr   <= dwell_done ? (ptr == LAST ? '0 : ptr + 1'b1) : ptr;
                    wrap  <= scan_end;
                end else begin
                    cnt <= '0;
                    ptr <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_secuencial_02.sv
// tb_secuencial_02: directed-vector bench for secuencial_02 with W=4, N=3, DWELL=2
module tb_secuencial_02;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [11:0] din;
    logic [3:0]  z;
    logic [1:0]  ch;
    logic        valid;
    logic        wrap;
    int n_vec = 0;
    int n_err = 0;

    secuencial_02 #(.W(4), .N(3), .DWELL(2)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .sel(sel),
        .din(din), .z(z), .ch(ch), .valid(valid), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] ez, input logic [1:0] ech,
                              input logic ev, input logic ew);
        chk({tag, ".z"}, 32'(z), 32'(ez));
        chk({tag, ".ch"}, 32'(ch), 32'(ech));
        chk({tag, ".valid"}, 32'(valid), 32'(ev));
        chk({tag, ".wrap"}, 32'(wrap), 32'(ew));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; enable = 1'b1; mode = 2'b01; sel = 2'd0; din = 12'hCBA;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("reset", 4'h0, 2'd0, 1'b0, 1'b0);
        end
        rst = 1'b1;

        mode = 2'b00;
        sel = 2'd1; step(); expect_out("man_sel1", 4'hB, 2'd1, 1'b1, 1'b0);
        sel = 2'd2; step(); expect_out("man_sel2", 4'hC, 2'd2, 1'b1, 1'b0);
        sel = 2'd3; step(); expect_out("man_sel3", 4'h0, 2'd3, 1'b0, 1'b0);

        mode = 2'b01;
        for (int i = 0; i < 12; i++) begin
            step();
            expect_out("scan", 4'hA + 4'((i / 2) % 3), 2'((i / 2) % 3), 1'b1, (i % 6) == 5);
        end

        step(); expect_out("pause_a0", 4'hA, 2'd0, 1'b1, 1'b0);
        step(); expect_out("pause_a1", 4'hA, 2'd0, 1'b1, 1'b0);
        step(); expect_out("pause_b0", 4'hB, 2'd1, 1'b1, 1'b0);
        enable = 1'b0;
        din = 12'h123;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_out("paused", 4'hB, 2'd1, 1'b1, 1'b0);
        end
        din = 12'hCBA;
        enable = 1'b1;
        step(); expect_out("resume_b1", 4'hB, 2'd1, 1'b1, 1'b0);
        step(); expect_out("resume_c0", 4'hC, 2'd2, 1'b1, 1'b0);
        step(); expect_out("resume_c1", 4'hC, 2'd2, 1'b1, 1'b1);

        for (int i = 0; i < 5; i++) step();
        expect_out("pre_hold", 4'hC, 2'd2, 1'b1, 1'b0);
        mode = 2'b10;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_out("hold", 4'hC, 2'd2, 1'b1, 1'b0);
        end
        mode = 2'b01;
        step(); expect_out("reentry_a0", 4'hA, 2'd0, 1'b1, 1'b0);
        step(); expect_out("reentry_a1", 4'hA, 2'd0, 1'b1, 1'b0);
        step(); expect_out("reentry_b0", 4'hB, 2'd1, 1'b1, 1'b0);

        step(); expect_out("mid_b1", 4'hB, 2'd1, 1'b1, 1'b0);
        step(); expect_out("mid_c0", 4'hC, 2'd2, 1'b1, 1'b0);
        rst = 1'b0;
        step(); expect_out("mid_reset", 4'h0, 2'd0, 1'b0, 1'b0);
        rst = 1'b1;
        step(); expect_out("restart_a0", 4'hA, 2'd0, 1'b1, 1'b0);
        step(); expect_out("restart_a1", 4'hA, 2'd0, 1'b1, 1'b0);
        step(); expect_out("restart_b0", 4'hB, 2'd1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
